// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory / MMIO block: funct3 codes, default
// MMIO addresses, STAT layout, drain FSM states and byte-lane helpers.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] UART_TX_ADDR_DEF   = 32'hf6fff070;
  localparam logic [31:0] UART_STAT_ADDR_DEF = 32'hf6fff074;
  localparam logic [31:0] HC_ADDR_DEF        = 32'hffffff00;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } drain_state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_RAM  = 2'd1,
    RSP_MMIO = 2'd2
  } rsp_kind_e;

  // Byte offset k lives in word bits [31-8k:24-8k]; values are little-endian.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] le_v;
    logic [31:0] sh_v;
    logic [31:0] res_v;
    le_v = {word[7:0], word[15:8], word[23:16], word[31:24]};
    sh_v = le_v >> {off, 3'b000};
    case (f3)
      F3_LB:   res_v = {{24{sh_v[7]}}, sh_v[7:0]};
      F3_LBU:  res_v = {24'h000000, sh_v[7:0]};
      F3_LH:   res_v = {{16{sh_v[15]}}, sh_v[15:0]};
      F3_LHU:  res_v = {16'h0000, sh_v[15:0]};
      F3_LW:   res_v = sh_v;
      default: res_v = 32'h00000000;
    endcase
    return res_v;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                              input logic [1:0]  off);
    logic [31:0] res_v;
    logic [1:0]  j_v;
    res_v = 32'h00000000;
    for (int l = 0; l < 4; l++) begin
      j_v = 2'(l) - off;
      res_v[(31 - 8*l) -: 8] = wdata[{j_v, 3'b000} +: 8];
    end
    return res_v;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [3:0] m_v;
    case (f3[1:0])
      2'b00:   m_v = 4'b0001 << off;
      2'b01:   m_v = 4'b0011 << off;
      2'b10:   m_v = 4'b1111;
      default: m_v = 4'b0000;
    endcase
    return m_v;
  endfunction

endpackage

// File: rtl/dmem_mmio_fifo.sv
// Synchronous FIFO with occupancy count; push when full and pop when empty
// are ignored. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] buf_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = buf_r[rd_ptr_r];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage, not reset
  always_ff @(posedge clk) begin
    if (do_push_s) buf_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM with byte/half/word access and a registered 1-cycle read, plus MMIO
// decode for a FIFO-buffered UART TX path, UART status and hardware counter.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 24576,
  parameter string       INIT_FILE      = "",
  parameter logic [31:0] UART_TX_ADDR   = UART_TX_ADDR_DEF,
  parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter logic [31:0] HC_ADDR        = HC_ADDR_DEF,
  parameter int          TXQ_DEPTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [31:0] hc_OUT_data,
  input  logic        uart_busy,
  input  logic        uart_OUT_data,
  output logic [7:0]  uart_IN_data,
  output logic        uart_we,
  output logic        uart_tx
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [31:0]      ram_q_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  rsp_kind_e        rsp_kind_r;
  logic [1:0]       off_r;
  logic [2:0]       f3_r;
  logic [31:0]      mmio_q_r;
  drain_state_e     state_r;
  drain_state_e     state_next_s;
  logic             uart_we_r;
  logic [7:0]       tx_data_r;

  logic             is_tx_s, is_stat_s, is_hc_s, mmio_s;
  logic [1:0]       off_s;
  logic [IDX_W-1:0] widx_s;
  logic             f3_bad_s, misal_s, range_s, mmio_bad_s, err_s;
  logic             accept_s, push_s, pop_s, ram_we_s, ram_re_s;
  logic [3:0]       lane_we_s;
  logic [31:0]      wlane_s;
  logic [31:0]      stat_word_s;
  logic [7:0]       fifo_head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  assign is_tx_s   = (req_addr == UART_TX_ADDR);
  assign is_stat_s = (req_addr == UART_STAT_ADDR);
  assign is_hc_s   = (req_addr == HC_ADDR);
  assign mmio_s    = is_tx_s || is_stat_s || is_hc_s;
  assign off_s     = req_addr[1:0];
  assign widx_s    = req_addr[IDX_W+1:2];

  // Stores only have SB/SH/SW; loads reject 011/110/111.
  assign f3_bad_s   = req_we ? (req_funct3[2] || (&req_funct3[1:0]))
                             : ((&req_funct3[1:0]) || (req_funct3[2] && req_funct3[1]));
  assign misal_s    = ((req_funct3[1:0] == 2'b01) && (off_s == 2'b11)) ||
                      ((req_funct3[1:0] == 2'b10) && (off_s != 2'b00));
  assign range_s    = !mmio_s && (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign mmio_bad_s = is_tx_s ? !(req_we && ((req_funct3 == F3_SB) || (req_funct3 == F3_SW)))
                              : ((is_stat_s || is_hc_s) && (req_we || (req_funct3 != F3_LW)));
  assign err_s      = f3_bad_s || misal_s || range_s || mmio_bad_s;

  assign req_ready = !(req_we && is_tx_s && fifo_full_s);
  assign accept_s  = req_valid && req_ready;
  assign push_s    = accept_s && !err_s && is_tx_s && req_we;
  assign ram_we_s  = accept_s && !err_s && req_we && !mmio_s;
  assign ram_re_s  = accept_s && !err_s && !req_we && !mmio_s;
  assign lane_we_s = ram_we_s ? lane_mask(off_s, req_funct3) : 4'b0000;
  assign wlane_s   = store_lanes(req_wdata, off_s);

  // status word seen by a STAT load
  always_comb begin
    stat_word_s = 32'h00000000;
    stat_word_s[STAT_COUNT_LSB +: 8] = 8'(fifo_count_s);
    stat_word_s[STAT_FULL_BIT]       = fifo_full_s;
    stat_word_s[STAT_EMPTY_BIT]      = fifo_empty_s;
  end

  // RAM port: per-lane writes and registered read (contents never reset)
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we_s[l]) mem_r[widx_s][(31 - 8*l) -: 8] <= wlane_s[(31 - 8*l) -: 8];
    end
    if (ram_re_s) ram_q_r <= mem_r[widx_s];
  end

  // response pipeline: remembers what the accepted request needs formatted
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_kind_r  <= RSP_NONE;
      off_r       <= 2'b00;
      f3_r        <= 3'b000;
      mmio_q_r    <= 32'h00000000;
    end else begin
      rsp_valid_r <= accept_s;
      rsp_err_r   <= accept_s && err_s;
      off_r       <= off_s;
      f3_r        <= req_funct3;
      if (!accept_s || err_s || req_we) rsp_kind_r <= RSP_NONE;
      else if (mmio_s)                  rsp_kind_r <= RSP_MMIO;
      else                              rsp_kind_r <= RSP_RAM;
      if (accept_s) mmio_q_r <= is_hc_s ? hc_OUT_data : stat_word_s;
    end
  end

  // load formatting on the registered RAM word
  always_comb begin
    rsp_rdata = 32'h00000000;
    case (rsp_kind_r)
      RSP_RAM:  rsp_rdata = load_format(ram_q_r, off_r, f3_r);
      RSP_MMIO: rsp_rdata = mmio_q_r;
      default:  rsp_rdata = 32'h00000000;
    endcase
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (req_wdata[7:0]),
    .pop   (pop_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // drain FSM next state; GUARD gives the UART a cycle to raise busy
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = (!fifo_empty_s && !uart_busy) ? ST_SEND : ST_IDLE;
      ST_SEND:  state_next_s = ST_GUARD;
      ST_GUARD: state_next_s = ST_WAIT;
      ST_WAIT:  state_next_s = uart_busy ? ST_WAIT : ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // drain FSM outputs
  always_comb begin
    pop_s = 1'b0;
    if (state_r == ST_SEND) pop_s = 1'b1;
    else                    pop_s = 1'b0;
  end

  // registered UART strobe/data, aligned with the SEND state
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_we_r <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      uart_we_r <= (state_next_s == ST_SEND);
      if (state_next_s == ST_SEND) tx_data_r <= fifo_head_s;
    end
  end

  assign uart_we      = uart_we_r;
  assign uart_IN_data = tx_data_r;
  assign uart_tx      = uart_OUT_data;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM load/store formatting,
// error handling, HC/STAT reads and the UART TX queue with its drain FSM.
module tb_dmem_mmio;

  localparam int          DEPTH_WORDS = 24576;
  localparam logic [31:0] TX_A   = 32'hf6fff070;
  localparam logic [31:0] STAT_A = 32'hf6fff074;
  localparam logic [31:0] HC_A   = 32'hffffff00;
  localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0]  SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] hc_OUT_data;
  logic        uart_busy, uart_OUT_data;
  logic [7:0]  uart_IN_data;
  logic        uart_we, uart_tx;

  int          checks = 0;
  int          failures = 0;
  logic        seen_ready, got_valid, got_err;
  logic [31:0] got_rdata;
  logic [7:0]  strobe_log[$];
  int          busy_viol = 0;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hc_OUT_data(hc_OUT_data), .uart_busy(uart_busy), .uart_OUT_data(uart_OUT_data),
    .uart_IN_data(uart_IN_data), .uart_we(uart_we), .uart_tx(uart_tx)
  );

  always @(posedge clk) begin
    if (uart_we) begin
      strobe_log.push_back(uart_IN_data);
      if (uart_busy) busy_viol <= busy_viol + 1;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    #1 seen_ready = req_ready;
    @(posedge clk); #1;
    got_valid = rsp_valid; got_rdata = rsp_rdata; got_err = rsp_err;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset_rsp: valid=%b rdata=%h err=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (uart_we !== 1'b0 || uart_IN_data !== 8'h00) begin
      failures++; $display("FAIL reset_uart: we=%b data=%h want 0/00", uart_we, uart_IN_data);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    rst = 1'b0;
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== 32'h00000001) begin
      failures++; $display("FAIL reset_stat: v=%b e=%b rdata=%h want 1/0/00000001", got_valid, got_err, got_rdata);
    end
    uart_OUT_data = 1'b1; #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++; $display("FAIL uart_tx_pass: got %b want 1", uart_tx);
    end
    uart_OUT_data = 1'b0;
  endtask

  task automatic test_word_load();
    logic [31:0] addrs [6];
    logic [2:0]  f3s   [6];
    logic [31:0] exps  [6];
    addrs = '{32'h100, 32'h100, 32'h103, 32'h102, 32'h100, 32'h101};
    f3s   = '{LW, LB, LBU, LH, LHU, LB};
    exps  = '{32'h11223344, 32'h00000044, 32'h00000011, 32'h00001122, 32'h00003344, 32'h00000033};
    do_req(1'b1, 32'h100, 32'h11223344, SW);
    checks++;
    if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== 32'h0) begin
      failures++; $display("FAIL sw_rsp: v=%b e=%b rdata=%h want 1/0/0", got_valid, got_err, got_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, addrs[i], 32'h0, f3s[i]);
      checks++;
      if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== exps[i]) begin
        failures++;
        $display("FAIL word_load_%0d: v=%b e=%b rdata=%h want 1/0/%h", i, got_valid, got_err, got_rdata, exps[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rsp_one_cycle: valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] addrs [7];
    logic [2:0]  f3s   [7];
    logic [31:0] exps  [7];
    addrs = '{32'h205, 32'h205, 32'h204, 32'h206, 32'h206, 32'h204, 32'h205};
    f3s   = '{LB, LBU, LW, LH, LHU, LW, LH};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'hA1B280D4, 32'hFFFFA1B2, 32'h0000A1B2, 32'hBE7766D4, 32'h00007766};
    do_req(1'b1, 32'h204, 32'hA1B2C3D4, SW);
    do_req(1'b1, 32'h205, 32'h12345680, SB);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        do_req(1'b1, 32'h206, 32'h0000BEEF, SH);
        do_req(1'b1, 32'h205, 32'hFFFF7766, SH);
      end
      do_req(1'b0, addrs[i], 32'h0, f3s[i]);
      checks++;
      if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== exps[i]) begin
        failures++;
        $display("FAIL byte_store_%0d: v=%b e=%b rdata=%h want 1/0/%h", i, got_valid, got_err, got_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        wes   [9];
    logic [31:0] addrs [9];
    logic [2:0]  f3s   [9];
    wes   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    addrs = '{32'h3, 32'h2, 32'(DEPTH_WORDS * 4), 32'h0, STAT_A, HC_A, TX_A, TX_A, 32'h3};
    f3s   = '{LH, SW, LW, 3'b011, SW, LB, SH, LW, SH};
    do_req(1'b1, 32'h0, 32'hCAFEF00D, SW);
    for (int i = 0; i < 9; i++) begin
      do_req(wes[i], addrs[i], 32'hDEADDEAD, f3s[i]);
      checks++;
      if (got_valid !== 1'b1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
        failures++;
        $display("FAIL err_case_%0d: v=%b e=%b rdata=%h want 1/1/0", i, got_valid, got_err, got_rdata);
      end
    end
    do_req(1'b0, 32'h0, 32'h0, LW);
    checks++;
    if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL err_no_corrupt: v=%b e=%b rdata=%h want 1/0/cafef00d", got_valid, got_err, got_rdata);
    end
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00000001) begin
      failures++; $display("FAIL err_no_push: stat=%h want 00000001", got_rdata);
    end
  endtask

  task automatic test_hc();
    hc_OUT_data = 32'hDEADBEEF;
    do_req(1'b0, HC_A, 32'h0, LW);
    hc_OUT_data = 32'h12345678;
    #1;
    checks++;
    if (got_valid !== 1'b1 || got_err !== 1'b0 || got_rdata !== 32'hDEADBEEF || rsp_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL hc_read: v=%b e=%b rdata=%h now=%h want deadbeef", got_valid, got_err, got_rdata, rsp_rdata);
    end
  endtask

  task automatic test_uart_drain();
    logic [7:0]  exp_b [3];
    logic [31:0] exp_stat;
    int          n;
    exp_b = '{8'h41, 8'h42, 8'h43};
    uart_busy = 1'b1;
    strobe_log.delete();
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, TX_A, {24'h0, exp_b[i]}, SB);
      checks++;
      if (seen_ready !== 1'b1 || got_valid !== 1'b1 || got_err !== 1'b0) begin
        failures++; $display("FAIL tx_push_%0d: ready=%b v=%b e=%b want 1/1/0", i, seen_ready, got_valid, got_err);
      end
    end
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00000300) begin
      failures++; $display("FAIL stat_3: got %h want 00000300", got_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      uart_busy = 1'b0;
      n = 0;
      while (uart_we !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (uart_we !== 1'b1 || uart_IN_data !== exp_b[i]) begin
        failures++; $display("FAIL tx_strobe_%0d: we=%b data=%h want 1/%h", i, uart_we, uart_IN_data, exp_b[i]);
      end
      @(posedge clk); #1;
      uart_busy = 1'b1;
      do_req(1'b0, STAT_A, 32'h0, LW);
      exp_stat = (i == 2) ? 32'h00000001 : (32'(2 - i) << 8);
      checks++;
      if (got_rdata !== exp_stat) begin
        failures++; $display("FAIL stat_drain_%0d: got %h want %h", i, got_rdata, exp_stat);
      end
      repeat (9) @(posedge clk);
      #1;
    end
    uart_busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (strobe_log.size() !== 3 || busy_viol !== 0) begin
      failures++; $display("FAIL tx_strobe_count: strobes=%0d busy_viol=%0d want 3/0", strobe_log.size(), busy_viol);
    end
    checks++;
    if ({strobe_log[0], strobe_log[1], strobe_log[2]} !== 24'h414243) begin
      failures++; $display("FAIL tx_order: got %h%h%h want 414243", strobe_log[0], strobe_log[1], strobe_log[2]);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    int n;
    int strobes0;
    uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, TX_A, 32'h60 + 32'(i), SB);
      if (seen_ready !== 1'b1 || got_valid !== 1'b1 || got_err !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL fill_pushes: bad=%0d want 0", bad);
    end
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00001002) begin
      failures++; $display("FAIL stat_full: got %h want 00001002", got_rdata);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = TX_A; req_wdata = 32'h70; req_funct3 = SB;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL ready_full: got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL no_accept_full: rsp_valid=%b want 0", rsp_valid);
    end
    strobes0 = strobe_log.size();
    uart_busy = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 2 || strobe_log.size() !== strobes0 + 1) begin
      failures++; $display("FAIL ready_after_pop: cycles=%0d strobes=%0d want 2/%0d", n, strobe_log.size(), strobes0 + 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    uart_busy = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL push17_accept: v=%b e=%b want 1/0", rsp_valid, rsp_err);
    end
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00001002) begin
      failures++; $display("FAIL stat_refull: got %h want 00001002", got_rdata);
    end
  endtask

  task automatic test_reset_midsend();
    int n;
    int strobes0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    uart_busy = 1'b1;
    for (int i = 0; i < 5; i++) do_req(1'b1, TX_A, 32'h30 + 32'(i), SB);
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00000500) begin
      failures++; $display("FAIL stat_5: got %h want 00000500", got_rdata);
    end
    uart_busy = 1'b0;
    n = 0;
    while (uart_we !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (uart_we !== 1'b1 || uart_IN_data !== 8'h30) begin
      failures++; $display("FAIL midsend_strobe: we=%b data=%h want 1/30", uart_we, uart_IN_data);
    end
    @(posedge clk); #1;
    uart_busy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_funct3 = LW;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (uart_we !== 1'b0 || uart_IN_data !== 8'h00 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_midsend: we=%b data=%h rsp_valid=%b want 0/00/0", uart_we, uart_IN_data, rsp_valid);
    end
    rst = 1'b0; req_valid = 1'b0;
    uart_busy = 1'b0;
    strobes0 = strobe_log.size();
    do_req(1'b0, STAT_A, 32'h0, LW);
    checks++;
    if (got_rdata !== 32'h00000001) begin
      failures++; $display("FAIL stat_after_reset: got %h want 00000001", got_rdata);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (strobe_log.size() !== strobes0) begin
      failures++; $display("FAIL no_send_after_reset: strobes=%0d want %0d", strobe_log.size(), strobes0);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_funct3 = 3'b000; hc_OUT_data = 32'h0; uart_busy = 1'b0; uart_OUT_data = 1'b0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_errors();
    test_hc();
    test_uart_drain();
    test_full();
    test_reset_midsend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
